// File: rtl/audio_pkg.sv
// Shared audio constants and helpers for the I2S transmit path.
// Contents:
//   *_DFLT localparams  default sample/slot widths, clock divider, request latency
//   sample_t            signed sample type at the default width
//   frame_bclks()       BCLK periods per stereo frame for a given slot width
//   cnt_width()         register width able to hold 0..n-1 (at least 1 bit)
package audio_pkg;

  localparam int DATA_WDTH_DFLT   = 24;
  localparam int SLOT_WDTH_DFLT   = 32;
  localparam int CLK_DIV_DFLT     = 2;
  localparam int REQ_LAT_DFLT     = 3;
  localparam int FRAME_BCLKS_DFLT = 2 * SLOT_WDTH_DFLT;

  typedef logic signed [DATA_WDTH_DFLT-1:0] sample_t;

  function automatic int frame_bclks(input int slot_wdth);
    return 2 * slot_wdth;
  endfunction

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/i2s_clkgen.sv
// BCLK generator: a prescaler counting 0..CLK_DIV-1 toggles bclk on every wrap.
// Ports:
//   clk, rst     system clock, asynchronous active-high reset
//   bclk_o       registered bit clock (0 after reset)
//   fall_evt_o   high for the one clk whose closing edge drives bclk 1->0
//   rise_evt_o   high for the one clk whose closing edge drives bclk 0->1
// The strobes are combinational and lead bclk by one edge, so logic that
// registers on a strobe changes in the same clk edge as bclk itself.
module i2s_clkgen
  import audio_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DFLT
) (
  input  logic clk,
  input  logic rst,
  output logic bclk_o,
  output logic fall_evt_o,
  output logic rise_evt_o
);

  localparam int DIV_W = cnt_width(CLK_DIV);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             bclk_q, bclk_d;
  logic             wrap;

  assign wrap = (div_cnt_q == DIV_W'(CLK_DIV - 1));

  always_comb begin
    div_cnt_d = wrap ? '0 : div_cnt_q + DIV_W'(1);
    bclk_d    = wrap ? ~bclk_q : bclk_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_q <= '0;
      bclk_q    <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      bclk_q    <= bclk_d;
    end
  end

  assign bclk_o     = bclk_q;
  assign fall_evt_o = wrap & bclk_q;
  assign rise_evt_o = wrap & ~bclk_q;

endmodule

// File: rtl/i2s_tx.sv
// I2S transmitter for a mono DDS source: once per frame it pulses sample_req,
// captures sample_in REQ_LAT clks later into hold, loads hold into the shift
// register at frame start and sends that value in both the left and right slot.
// Ports:
//   clk, rst     system clock, asynchronous active-high reset
//   sample_req   one-clk request pulse to the DDS, once per frame
//   sample_in    signed DATA_WDTH-bit sample, sampled REQ_LAT clks after sample_req
//   bclk         bit clock, f_clk / (2*CLK_DIV)
//   lrclk        word select, 0 = left slot, 1 = right slot
//   sdata        serial data, MSB first, changes with bclk falling
// Request/response contract: there is no valid/ready pair. sample_req is a
// single-clk strobe, and the DDS must present the answer on sample_in at the
// clk edge exactly REQ_LAT clks after the edge that raised sample_req; that
// edge is the only one at which sample_in is looked at.
// Build option: define I2S_LEFT_JUST_EN for left-justified framing (MSB in
// slot bit 0); without it, standard I2S framing (MSB in slot bit 1).
module i2s_tx
  import audio_pkg::*;
#(
  parameter int DATA_WDTH = DATA_WDTH_DFLT,
  parameter int SLOT_WDTH = SLOT_WDTH_DFLT,
  parameter int CLK_DIV   = CLK_DIV_DFLT,
  parameter int REQ_LAT   = REQ_LAT_DFLT
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 sample_req,
  input  logic [DATA_WDTH-1:0] sample_in,
  output logic                 bclk,
  output logic                 lrclk,
  output logic                 sdata
);

  localparam int FRAME = frame_bclks(SLOT_WDTH);
  localparam int CNT_W = cnt_width(FRAME);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME - 1);
  localparam logic [CNT_W-1:0] REQ_BIT  = CNT_W'(FRAME - 2);
  localparam logic [CNT_W-1:0] SLOT_LEN = CNT_W'(SLOT_WDTH);

  // Slot bit index that carries the MSB.
`ifdef I2S_LEFT_JUST_EN
  localparam int DATA_OFS = 0;
`else
  localparam int DATA_OFS = 1;
`endif

  // The request goes out two BCLK falls before frame start, so the answer
  // must land within 4*CLK_DIV clks.
  if (REQ_LAT < 1) begin : g_err_lat_min
    $error("i2s_tx: REQ_LAT must be at least 1");
  end
  if (REQ_LAT >= 4 * CLK_DIV) begin : g_err_lat_max
    $error("i2s_tx: REQ_LAT must be below 4*CLK_DIV or the capture misses frame start");
  end
  if (SLOT_WDTH < DATA_WDTH + 1) begin : g_err_slot
    $error("i2s_tx: SLOT_WDTH must be at least DATA_WDTH+1");
  end
  if (CLK_DIV < 1) begin : g_err_div
    $error("i2s_tx: CLK_DIV must be at least 1");
  end

  logic fall_evt;
  logic rise_evt_unused;

  i2s_clkgen #(
    .CLK_DIV (CLK_DIV)
  ) u_clkgen (
    .clk        (clk),
    .rst        (rst),
    .bclk_o     (bclk),
    .fall_evt_o (fall_evt),
    .rise_evt_o (rise_evt_unused)
  );

  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic                 lrclk_q, lrclk_d;
  logic                 sdata_q, sdata_d;
  logic [REQ_LAT-1:0]   req_pipe_q, req_pipe_d;
  logic [DATA_WDTH-1:0] hold_q, hold_d;
  logic [DATA_WDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]     slot_bit;
  logic                 req_now;

  // Bit counter, frame-start load and serial output selection. Everything is
  // computed from the post-increment count so lrclk/sdata move with bclk.
  always_comb begin
    bit_cnt_d = bit_cnt_q;
    lrclk_d   = lrclk_q;
    sdata_d   = sdata_q;
    shreg_d   = shreg_q;
    slot_bit  = '0;
    req_now   = 1'b0;
    if (fall_evt) begin
      bit_cnt_d = (bit_cnt_q == LAST_BIT) ? '0 : bit_cnt_q + CNT_W'(1);
      if (bit_cnt_d == '0) begin
        shreg_d = hold_q;
      end
      lrclk_d  = (bit_cnt_d >= SLOT_LEN);
      slot_bit = lrclk_d ? (bit_cnt_d - SLOT_LEN) : bit_cnt_d;
      sdata_d  = 1'b0;
      for (int i = 0; i < DATA_WDTH; i++) begin
        if (slot_bit == CNT_W'(DATA_WDTH - 1 - i + DATA_OFS)) begin
          sdata_d = shreg_d[i];
        end
      end
      req_now = (bit_cnt_d == REQ_BIT);
    end
  end

  // req_pipe_q[0] is the request strobe itself; bit k is the strobe k clks
  // later, so the top bit marks the capture edge REQ_LAT clks after the pulse.
  always_comb begin
    req_pipe_d    = '0;
    req_pipe_d[0] = req_now;
    for (int i = 1; i < REQ_LAT; i++) begin
      req_pipe_d[i] = req_pipe_q[i-1];
    end
  end

  always_comb begin
    hold_d = hold_q;
    if (req_pipe_q[REQ_LAT-1]) begin
      hold_d = sample_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt_q  <= LAST_BIT;
      lrclk_q    <= 1'b0;
      sdata_q    <= 1'b0;
      req_pipe_q <= '0;
      hold_q     <= '0;
      shreg_q    <= '0;
    end else begin
      bit_cnt_q  <= bit_cnt_d;
      lrclk_q    <= lrclk_d;
      sdata_q    <= sdata_d;
      req_pipe_q <= req_pipe_d;
      hold_q     <= hold_d;
      shreg_q    <= shreg_d;
    end
  end

  assign sample_req = req_pipe_q[0];
  assign lrclk      = lrclk_q;
  assign sdata      = sdata_q;

endmodule

// File: tb/tb_i2s_tx.sv
// Bench for i2s_tx at the default configuration (24-bit data, 32-bit slots,
// CLK_DIV=2, REQ_LAT=3). A DDS model answers each request with a value from a
// directed table, then random values; sample_in carries random junk except at
// the single capture edge. A DAC-side monitor collects bits on bclk rises and
// compares each slot against the framing rules, using a queue of answered
// samples as the expected frame contents.
module tb_i2s_tx;

  localparam int D       = 24;
  localparam int S       = 32;
  localparam int CD      = 2;
  localparam int RL      = 3;
  localparam int FRAME_B = 2 * S;
  localparam int BCLK_T  = 2 * CD;
  localparam int FRAME_T = FRAME_B * BCLK_T;

  logic         clk = 1'b0;
  logic         rst;
  logic         sample_req;
  logic [D-1:0] sample_in;
  logic         bclk;
  logic         lrclk;
  logic         sdata;

  i2s_tx #(
    .DATA_WDTH (D),
    .SLOT_WDTH (S),
    .CLK_DIV   (CD),
    .REQ_LAT   (RL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sample_req (sample_req),
    .sample_in  (sample_in),
    .bclk       (bclk),
    .lrclk      (lrclk),
    .sdata      (sdata)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // model state
  logic [D-1:0] exp_q[$];
  logic [D-1:0] tbl[6] = '{24'hA5F00F, 24'h800000, 24'h7FFFFF, 24'h800000, 24'h7FFFFF, 24'h800001};
  int           req_idx = 0;
  logic [D-1:0] cur_val;
  int           cyc, r_cnt, last_req_cyc, slot_cyc, last_rise_cyc;
  bit           synced, prev_bclk, prev_req;
  bit           dds_busy, dds_drove;
  int           dds_wait;
  logic [31:0]  d_word, lr_word;

  // Expected 32-bit slot content, MSB first: I2S puts one idle bit before the
  // sample, left-justified puts the sample first; the rest is zero padding.
  function automatic logic [31:0] slot_word(input logic [D-1:0] v);
    logic [31:0] w;
    w = 32'(v);
`ifdef I2S_LEFT_JUST_EN
    return w << (S - D);
`else
    return w << (S - 1 - D);
`endif
  endfunction

  task automatic model_reset();
    exp_q.delete();
    exp_q.push_back('0);
    cur_val      = '0;
    cyc          = 0;
    r_cnt        = 0;
    last_req_cyc = -1;
    slot_cyc     = 0;
    last_rise_cyc = 0;
    synced       = 1'b0;
    dds_busy     = 1'b0;
    dds_drove    = 1'b0;
    dds_wait     = 0;
    d_word       = '0;
    lr_word      = '0;
  endtask

  // driver: DDS answering each request at exactly REQ_LAT clks
  task automatic dds_step();
    logic [D-1:0] v;
    if (dds_drove) begin
      sample_in = D'($urandom);
      dds_drove = 1'b0;
    end
    if (sample_req) begin
      dds_busy = 1'b1;
      dds_wait = RL - 1;
    end
    if (dds_busy) begin
      if (dds_wait == 0) begin
        v = (req_idx < 6) ? tbl[req_idx] : D'($urandom);
        req_idx++;
        sample_in = v;
        exp_q.push_back(v);
        dds_busy  = 1'b0;
        dds_drove = 1'b1;
      end else begin
        dds_wait--;
      end
    end
  endtask

  task automatic req_step();
    if (sample_req) begin
      check("req_position", 32'(r_cnt % FRAME_B), 32'(FRAME_B - 2));
      check("req_single_clk", 32'(prev_req), 32'd0);
      if (last_req_cyc >= 0) check("req_period", 32'(cyc - last_req_cyc), 32'(FRAME_T));
      last_req_cyc = cyc;
    end
  endtask

  task automatic rise_step();
    int b;
    b = r_cnt % FRAME_B;
    if (r_cnt > 0) check("bclk_period", 32'(cyc - last_rise_cyc), 32'(BCLK_T));
    last_rise_cyc = cyc;
    if (b == 0) begin
      check("exp_q_nonempty", 32'(exp_q.size() != 0), 32'd1);
      cur_val = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
    end
    if (b % S == 0) begin
      if (r_cnt > 0) check("slot_len", 32'(cyc - slot_cyc), 32'(S * BCLK_T));
      slot_cyc = cyc;
      d_word   = '0;
      lr_word  = '0;
    end
    d_word  = {d_word[30:0], sdata};
    lr_word = {lr_word[30:0], lrclk};
    if (b % S == S - 1) begin
      check(b < S ? "left_data" : "right_data", d_word, slot_word(cur_val));
      check("lrclk_slot", lr_word, (b < S) ? 32'h0 : 32'hFFFF_FFFF);
    end
    r_cnt++;
  endtask

  // scoreboard / monitor, sampling at the falling clk edge
  initial begin
    sample_in = '0;
    model_reset();
    prev_bclk = 1'b0;
    prev_req  = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        model_reset();
      end else begin
        cyc++;
        dds_step();
        req_step();
        if (bclk && !prev_bclk && synced) rise_step();
        if (!bclk && prev_bclk && !synced) begin
          check("first_fall_lrclk", 32'(lrclk), 32'd0);
          synced = 1'b1;
        end
      end
      prev_bclk = bclk;
      prev_req  = sample_req;
    end
  end

  task automatic check_outputs_zero(input string tag);
    check({tag, "_bclk"}, 32'(bclk), 32'd0);
    check({tag, "_lrclk"}, 32'(lrclk), 32'd0);
    check({tag, "_sdata"}, 32'(sdata), 32'd0);
    check({tag, "_req"}, 32'(sample_req), 32'd0);
  endtask

  task automatic release_and_run(input int frames);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    repeat (frames * FRAME_T) @(negedge clk);
  endtask

  // main sequence
  initial begin
    int k;
    rst = 1'b1;
    repeat (4) @(negedge clk);
    check_outputs_zero("reset");
    #2 rst = 1'b0;
    repeat (10 * FRAME_T) @(negedge clk);

    // reset in the middle of the right slot while bclk is high
    for (k = 0; k < 600; k++) begin
      @(negedge clk);
      if (lrclk && bclk) break;
    end
    check("wait_right_slot", 32'(k < 600), 32'd1);
    #2 rst = 1'b1;
    #1 check_outputs_zero("async_reset_mid_frame");
    release_and_run(3);

    // reset while a request is in flight: the answer must be discarded
    for (k = 0; k < 600; k++) begin
      @(negedge clk);
      if (sample_req) break;
    end
    check("wait_request", 32'(k < 600), 32'd1);
    #2 rst = 1'b1;
    #1 check_outputs_zero("async_reset_in_flight");
    release_and_run(5);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  // watchdog
  initial begin
    #2_000_000;
    n_bad++;
    $display("FAIL watchdog: run did not complete, got=timeout expected=finish");
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
